// File: rtl/core_pkg.sv
// Shared constants for the RV64 Zba front end: datapath width, the canonical NOP
// and the major opcodes that decode slices out of instr_d.
package core_pkg;
    localparam int          XLEN      = 64;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
endpackage

// File: rtl/fetch_fifo.sv
// IF/ID boundary FIFO holding {pc, instr} entries.
// The head is read combinationally, and flush wins over push and pop.
module fetch_fifo #(
    parameter  int WIDTH = 96,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [AW:0]      count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
        end
    end

    // Storage needs no reset; entries are only observed behind count_o.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    // Upstream credit accounting must never push into a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !flush_i && count_q == (AW+1)'(DEPTH)));
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, issues credit-limited in-order imem requests,
// buffers responses for decode and discards stale responses after a redirect.
module fetch_stage #(
    parameter int              XLEN     = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall_d,
    output logic            instr_d_valid,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d
);
    import core_pkg::NOP_INSTR;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = XLEN + 32;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redir_tgt;
    logic [CW-1:0]   inflight_q, inflight_d, drop_q, drop_d, count;
    logic [EW-1:0]   head;
    logic            pop_req, credit, fire, drop_rsp, push, fifo_pop;

    assign pop_req  = instr_d_valid & ~stall_d;
    // Stale in-flight requests still hold credit until their responses return.
    assign credit   = ({1'b0, inflight_q} + {1'b0, count} - {{CW{1'b0}}, pop_req})
                      < (CW+1)'(DEPTH);
    assign imem_req_valid = rst_n & ~redirect_valid & credit;
    assign imem_req_addr  = fetch_pc_q;
    assign fire      = imem_req_valid & imem_req_ready;
    assign drop_rsp  = imem_rsp_valid & (drop_q != '0);
    assign push      = imem_rsp_valid & ~drop_rsp & ~redirect_valid;
    assign fifo_pop  = pop_req & ~redirect_valid;
    assign redir_tgt = redirect_pc & ~XLEN'(3);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        inflight_d = inflight_q + {{(CW-1){1'b0}}, fire} - {{(CW-1){1'b0}}, imem_rsp_valid};
        if (redirect_valid) begin
            fetch_pc_d = redir_tgt;
            resp_pc_d  = redir_tgt;
            drop_d     = inflight_q - {{(CW-1){1'b0}}, imem_rsp_valid};
        end else begin
            if (fire)     fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (push)     resp_pc_d  = resp_pc_q + XLEN'(4);
            if (drop_rsp) drop_d     = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (push),
        .wdata_i ({resp_pc_q, imem_rsp_data}),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .count_o (count)
    );

    // With an empty FIFO, pc_d shows the PC the next response will carry.
    assign instr_d_valid = (count != '0);
    assign instr_d       = instr_d_valid ? head[31:0] : NOP_INSTR;
    assign pc_d          = instr_d_valid ? head[EW-1:32] : resp_pc_q;
    assign pc_plus4_d    = pc_d + XLEN'(4);
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order, fixed-latency instruction memory.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid, stall_d;
    logic [63:0] redirect_pc;
    logic        instr_d_valid;
    logic [31:0] instr_d;
    logic [63:0] pc_d, pc_plus4_d;

    int          n_cmp = 0, n_err = 0;
    int          cyc = 0, lat = 1;
    logic [63:0] mq_addr[$];
    int          mq_due[$];

    fetch_stage #(.XLEN(64), .RESET_PC(64'h0), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_d(stall_d),
        .instr_d_valid(instr_d_valid), .instr_d(instr_d),
        .pc_d(pc_d), .pc_plus4_d(pc_plus4_d)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[21:2], 12'h093};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Ends the current cycle (recording any accepted request) and drives the
    // memory response for the new cycle; returns 1 time unit after the edge.
    task automatic tick();
        #1;
        if (rst_n && imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + lat);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (mq_due.size() > 0 && mq_due[0] == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEADBEEF;
        end
    endtask

    task automatic enter_reset();
        rst_n = 1'b0;
        imem_rsp_valid = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        #1;
        chk("rst_instr_valid", instr_d_valid, 1'b0);
        chk("rst_instr_nop", instr_d, 32'h00000013);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_pc_d", pc_d, 64'h0);
    endtask

    // Leaves reset 1 unit after an edge: the caller is then in cycle 1.
    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; imem_req_ready = 1'b1; stall_d = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        #2;

        // Streaming at latency 1
        enter_reset();
        release_reset();
        #1; chk("t1_req_valid", imem_req_valid, 1'b1); chk("t1_req_a0", imem_req_addr, 64'h0);
        tick();
        #1; chk("t1_req_a1", imem_req_addr, 64'h4); chk("t1_c2_invalid", instr_d_valid, 1'b0);
        tick();
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t1_valid", instr_d_valid, 1'b1);
            chk("t1_pc_d", pc_d, 64'(4 * k));
            chk("t1_instr", instr_d, mem_word(64'(4 * k)));
            chk("t1_req_addr", imem_req_addr, 64'(4 * (k + 2)));
            if (k == 0) chk("t1_pc_plus4", pc_plus4_d, 64'h4);
            tick();
        end

        // Decode stall for 6 cycles, then drain
        stall_d = 1'b1;
        for (int s = 0; s < 6; s++) begin
            #1;
            chk("t2_stall_pc", pc_d, 64'd24);
            chk("t2_stall_instr", instr_d, mem_word(64'd24));
            if (s >= 2) chk("t2_credit_stop", imem_req_valid, 1'b0);
            tick();
        end
        stall_d = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t2_drain_valid", instr_d_valid, 1'b1);
            chk("t2_drain_pc", pc_d, 64'(24 + 4 * k));
            tick();
        end

        // Latency 3, two requests in flight, redirect to 0x100
        enter_reset();
        lat = 3; imem_req_ready = 1'b0;
        release_reset();
        redirect_valid = 1'b1; redirect_pc = 64'h10;
        #1; chk("t3_redir1_noreq", imem_req_valid, 1'b0);
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        #1; chk("t3_req_10", imem_req_addr, 64'h10);
        tick();
        #1; chk("t3_req_14", imem_req_addr, 64'h14);
        tick();
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h100;
        #1; chk("t3_redir_noreq", imem_req_valid, 1'b0);
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        #1; chk("t3_req_100", imem_req_addr, 64'h100); chk("t3_req_v", imem_req_valid, 1'b1);
        chk("t3_c5_invalid", instr_d_valid, 1'b0);
        tick();
        #1; chk("t3_stale0_dropped", instr_d_valid, 1'b0);
        tick();
        #1; chk("t3_stale1_dropped", instr_d_valid, 1'b0);
        tick();
        #1; chk("t3_c8_invalid", instr_d_valid, 1'b0);
        tick();
        #1; chk("t3_valid", instr_d_valid, 1'b1); chk("t3_pc_d", pc_d, 64'h100);
        chk("t3_instr", instr_d, mem_word(64'h100));
        tick();

        // Redirect while stalled with 3 buffered entries
        enter_reset();
        lat = 1; imem_req_ready = 1'b1; stall_d = 1'b1;
        release_reset();
        repeat (4) tick();
        #1; chk("t4_head_valid", instr_d_valid, 1'b1); chk("t4_head_pc", pc_d, 64'h0);
        chk("t4_full_noreq", imem_req_valid, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 64'h203;
        #1; chk("t4_redir_noreq", imem_req_valid, 1'b0);
        tick();
        redirect_valid = 1'b0; stall_d = 1'b0;
        #1; chk("t4_flushed", instr_d_valid, 1'b0); chk("t4_nop", instr_d, 32'h00000013);
        chk("t4_req_addr", imem_req_addr, 64'h200); chk("t4_req_v", imem_req_valid, 1'b1);
        tick();
        #1; chk("t4_req_204", imem_req_addr, 64'h204);
        tick();

        // imem_req_ready low for 5 cycles
        #1; chk("t5_valid", instr_d_valid, 1'b1); chk("t5_pc_200", pc_d, 64'h200);
        for (int r = 0; r < 5; r++) begin
            imem_req_ready = 1'b0;
            #1;
            chk("t5_addr_hold", imem_req_addr, 64'h208);
            chk("t5_req_v", imem_req_valid, 1'b1);
            if (r == 1) chk("t5_pc_204", pc_d, 64'h204);
            if (r >= 2) chk("t5_drained", instr_d_valid, 1'b0);
            tick();
        end
        imem_req_ready = 1'b1;
        #1; chk("t5_addr_resume", imem_req_addr, 64'h208);
        tick();
        #1; chk("t5_addr_20c", imem_req_addr, 64'h20C);
        tick();
        #1; chk("t5_pc_208", pc_d, 64'h208); chk("t5_valid_again", instr_d_valid, 1'b1);

        // Reset mid-stream with a non-empty FIFO
        stall_d = 1'b1;
        tick();
        #1; chk("t6_nonempty", instr_d_valid, 1'b1);
        enter_reset();
        stall_d = 1'b0;
        release_reset();
        #1; chk("t6_restart_addr", imem_req_addr, 64'h0); chk("t6_restart_v", imem_req_valid, 1'b1);
        tick();
        tick();
        #1; chk("t6_valid", instr_d_valid, 1'b1); chk("t6_pc_d", pc_d, 64'h0);
        chk("t6_instr", instr_d, mem_word(64'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the RV64 Zba pipeline, directly upstream of the decode controller.
- Owns the fetch PC and issues in-order requests to instruction memory.
- Buffers returned instruction words in a small FIFO that acts as the IF/ID boundary.
- Presents instr_d/pc_d to decode; decode slices OP/funct3/funct7 from instr_d. Handles decode stall and EX-stage branch/jump redirect, discarding stale in-flight responses.

Parameters:
XLEN, 64, address/PC width
RESET_PC, 64'h0, first fetch address after reset
DEPTH, 4, instruction FIFO entries and maximum in-flight requests (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  XLEN  fetch address, word aligned
imem_req_ready  in  1  memory accepts request this cycle
imem_rsp_valid  in  1  response word valid; in order; latency >=1 cycle
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  taken branch/JAL/JALR from EX
redirect_pc  in  XLEN  redirect target
stall_d  in  1  decode cannot accept an instruction this cycle
instr_d_valid  out  1  FIFO head valid
instr_d  out  32  FIFO head instruction; 32'h00000013 (addi x0,x0,0) when invalid
pc_d  out  XLEN  PC of instr_d
pc_plus4_d  out  XLEN  pc_d + 4, used for JAL/JALR link

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC; inflight = 0; drop_cnt = 0; FIFO empty.
  - imem_req_valid = 0, instr_d_valid = 0, instr_d = NOP, pc_d = RESET_PC.
  - First request is issued in the first cycle after reset release.
- Request issue:
  - pop = instr_d_valid & !stall_d.
  - imem_req_valid = !redirect_valid & (inflight + count - pop < DEPTH).
  - imem_req_addr = fetch_pc.
  - On req_valid & req_ready: fetch_pc += 4, inflight += 1.
- Each response decrements inflight.
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise it is pushed with its PC, taken from a resp_pc register that advances by 4 per accepted response.
- The credit rule guarantees a FIFO push never meets a full FIFO. Overflow is an assertion failure.
- Decode handshake:
  - Head entry is presented combinationally from FIFO registers.
  - The entry is held stable while stall_d=1.
  - It is popped on instr_d_valid & !stall_d.
- Throughput: with latency 1 and no stall, sustains 1 instruction/cycle.
- Redirect (redirect_valid=1):
  - FIFO flushed; the head is not popped even if stall_d=0.
  - fetch_pc and resp_pc are set to {redirect_pc[XLEN-1:2],2'b00}; low two bits are ignored.
  - drop_cnt = inflight_total - imem_rsp_valid. The response arriving this cycle is discarded, and stale inflight counts as outstanding.
  - inflight is updated normally.
  - No request is issued this cycle.
  - The first new-stream request goes out the next cycle.
- Simultaneous events:
  - Redirect beats stall and push.
  - Push and pop in the same cycle are both allowed.
  - When the FIFO is empty, a push is visible on instr_d the following cycle (no bypass).
- Wrap-around: fetch_pc wraps modulo 2^XLEN. FIFO pointers wrap modulo DEPTH.
- Reset mid-operation: all state clears immediately. Memory responses to pre-reset requests are not permitted; the bench must not generate them.

Decomposition:
- Shared package core_pkg holds:
  - NOP_INSTR = 32'h00000013.
  - XLEN.
  - Opcode constants (OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI), shared with the decode controller.
- One sub-module, fetch_fifo:
  - Parameterised width/depth, synchronous flush, push/pop, count output.
  - Stores {pc, instr}.
  - Counter/credit/drop logic stays in fetch_stage.

Test Plan:
- Reset release, RESET_PC=0x0, memory latency 1, always ready:
  - Requests go to 0x0, 0x4, 0x8, ... on consecutive cycles.
  - instr_d_valid first rises at cycle 3 after release, with pc_d=0x0 and pc_plus4_d=0x4.
  - One instruction is delivered per cycle thereafter.
- stall_d held high 6 cycles while streaming:
  - instr_d and pc_d are stable throughout.
  - Requests stop once inflight+count=4.
  - After release, 4 buffered instructions drain with PCs in order and none is lost or duplicated.
- Latency-3 memory with 2 requests in flight (0x10, 0x14), then redirect to 0x100:
  - Both stale responses are discarded.
  - The next instr_d has pc_d=0x100.
  - No request is issued in the redirect cycle.
- redirect_valid with stall_d=1 and FIFO holding 3 entries, redirect_pc=0x203:
  - FIFO is emptied and instr_d=NOP next cycle.
  - The next request address is 0x200.
- imem_req_ready low for 5 cycles:
  - imem_req_addr is held at the same PC.
  - fetch_pc does not advance.
  - instr_d_valid drops after the FIFO drains.
- rst_n asserted mid-stream with FIFO non-empty:
  - Outputs clear asynchronously (instr_d_valid=0, instr_d=NOP, imem_req_valid=0).
  - After release, fetch restarts at RESET_PC.
